// File: rtl/ws2812_pixel_receiver.sv
// rtl/ws2812_pixel_receiver.sv - WS2812-style NRZ pixel sink: captures the first 24 bits, forwards the rest
module ws2812_pixel_receiver #(
   parameter int MIN_HIGH     = 5,
   parameter int THRESH       = 29,
   parameter int MAX_HIGH     = 72,
   parameter int RESET_CYCLES = 2400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   output logic        dout,
   output logic [23:0] pixel,
   output logic        pixel_valid,
   output logic        frame_done,
   output logic        bit_error
);

   localparam int HW = $clog2(MAX_HIGH + 2);
   localparam int LW = $clog2(RESET_CYCLES + 1);

   localparam logic [HW-1:0] HC_MIN    = HW'(MIN_HIGH);
   localparam logic [HW-1:0] HC_THRESH = HW'(THRESH);
   localparam logic [HW-1:0] HC_MAX    = HW'(MAX_HIGH);
   localparam logic [HW-1:0] HC_SAT    = HW'(MAX_HIGH + 1);
   localparam logic [LW-1:0] LC_LATCH  = LW'(RESET_CYCLES);
   localparam logic [LW-1:0] LC_PRE    = LW'(RESET_CYCLES - 1);

   typedef enum logic [1:0] {
      CAPTURE,
      FORWARD,
      WAIT_LATCH
   } state_t;

   state_t        state, state_next;
   logic          sync1, ds, ds_d;
   logic [HW-1:0] high_cnt;
   logic [LW-1:0] low_cnt;
   logic [4:0]    bit_cnt, bit_cnt_next;
   logic [23:0]   shift, shift_next;
   logic          seen_rise;
   logic          load_pixel, set_err;

   logic rise, fall, stuck, latch;
   assign rise  = ds & ~ds_d;
   assign fall  = ~ds & ds_d;
   // Flag the cycle in which high_cnt would step past the legal maximum.
   assign stuck = ds & ~rise & (high_cnt == HC_MAX);
   assign latch = ~ds & (low_cnt == LC_PRE);

   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shift_next   = shift;
      load_pixel   = 1'b0;
      set_err      = 1'b0;
      if (latch) begin
         state_next   = CAPTURE;
         bit_cnt_next = 5'd0;
         shift_next   = 24'd0;
      end else begin
         case (state)
            CAPTURE: begin
               if (stuck) begin
                  set_err    = 1'b1;
                  state_next = WAIT_LATCH;
               end else if (bit_cnt == 5'd24) begin
                  load_pixel = 1'b1;
                  state_next = FORWARD;
               end else if (fall) begin
                  if (high_cnt < HC_MIN) begin
                     set_err      = 1'b1;
                     state_next   = WAIT_LATCH;
                     shift_next   = 24'd0;
                     bit_cnt_next = 5'd0;
                  end else if (high_cnt <= HC_MAX) begin
                     shift_next   = {shift[22:0], (high_cnt >= HC_THRESH)};
                     bit_cnt_next = bit_cnt + 5'd1;
                  end
               end
            end
            FORWARD: begin
               if (stuck) begin
                  set_err    = 1'b1;
                  state_next = WAIT_LATCH;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1       <= 1'b0;
         ds          <= 1'b0;
         ds_d        <= 1'b0;
         high_cnt    <= '0;
         low_cnt     <= '0;
         state       <= CAPTURE;
         bit_cnt     <= 5'd0;
         shift       <= 24'd0;
         pixel       <= 24'd0;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         bit_error   <= 1'b0;
         dout        <= 1'b0;
         seen_rise   <= 1'b0;
      end else begin
         sync1 <= din;
         ds    <= sync1;
         ds_d  <= ds;

         if (rise)
            high_cnt <= HW'(1);
         else if (ds && high_cnt != HC_SAT)
            high_cnt <= high_cnt + HW'(1);

         if (ds)
            low_cnt <= '0;
         else if (low_cnt != LC_LATCH)
            low_cnt <= low_cnt + LW'(1);

         state   <= state_next;
         bit_cnt <= bit_cnt_next;
         shift   <= shift_next;
         if (load_pixel)
            pixel <= shift;
         pixel_valid <= load_pixel;
         frame_done  <= latch & seen_rise;
         bit_error   <= bit_error | set_err;
         // Registered copy of ds keeps forwarded pulse widths exact.
         dout        <= (state_next == FORWARD) ? ds : 1'b0;

         if (latch)
            seen_rise <= 1'b0;
         else if (rise)
            seen_rise <= 1'b1;
      end
   end

endmodule
